// File: rtl/reg_file_gen.sv
// reg_file_gen: parametrised CPU register file with half-word write modes,
// optional write-to-read bypass, optional hard-wired zero R0 and a
// multi-cycle clear-all sweep engine with busy/done/drop status.
module reg_file_gen #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  output logic [DATA_W-1:0] value1,
  output logic [DATA_W-1:0] value2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_value_alu,
  input  logic [DATA_W-1:0] write_value_id,
  input  logic              write_data_sel,
  input  logic              write_enable,
  input  logic [1:0]        write_mode,
  input  logic              clr_all,
  output logic              busy,
  output logic              sweep_done,
  output logic              wr_drop
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int H        = DATA_W / 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              sweep_done_q, sweep_done_d;
  logic              wr_drop_q, wr_drop_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] cur;
  logic [DATA_W-1:0] merged;
  logic              write_hits_r0;
  logic              write_commit;
  logic              bypass_en;

  assign busy       = (state_q == SWEEP);
  assign sweep_done = sweep_done_q;
  assign wr_drop    = wr_drop_q;

  // Build the value a write would leave in its destination register.
  always_comb begin
    // NOTE: every variable written in an always_comb gets a value on every
    // path (defaults first); a missed path infers a latch.
    src    = write_data_sel ? write_value_id : write_value_alu;
    cur    = regs_q[write_addr];
    merged = src;
    case (write_mode)
      2'b01:   merged = {cur[DATA_W-1:H], src[H-1:0]};
      2'b10:   merged = {src[H-1:0], cur[H-1:0]};
      default: merged = src;
    endcase
  end

  assign write_hits_r0 = (ZERO_R0 != 0) && (write_addr == '0);
  assign write_commit  = write_enable && !busy && !write_hits_r0;
  // Bypass is gated by rst_n so the read ports stay at zero during reset.
  assign bypass_en     = (BYPASS != 0) && write_enable && !busy && rst_n;

  // Asynchronous read ports: stored value, optional bypass, zero-R0 override.
  always_comb begin
    value1 = regs_q[read_addr1];
    value2 = regs_q[read_addr2];
    if (bypass_en && (read_addr1 == write_addr)) value1 = merged;
    if (bypass_en && (read_addr2 == write_addr)) value2 = merged;
    if ((ZERO_R0 != 0) && (read_addr1 == '0)) value1 = '0;
    if ((ZERO_R0 != 0) && (read_addr2 == '0)) value2 = '0;
  end

  // Next-state logic: sweep FSM, status pulses and register updates.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    sweep_done_d = 1'b0;
    wr_drop_d    = write_enable && busy;
    regs_d       = regs_q;
    case (state_q)
      IDLE: begin
        if (clr_all) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        regs_d[idx_q] = '0;
        idx_d         = idx_q + ADDR_W'(1);
        // Completion is decided by the index compare, not by wrap-around.
        if (idx_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d      = IDLE;
          sweep_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Writes only commit outside a sweep, so they never collide with a clear.
    if (write_commit) regs_d[write_addr] = merged;
  end

  // State and register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      sweep_done_q <= 1'b0;
      wr_drop_q    <= 1'b0;
      // NOTE: the register array is reset here because the file must read
      // all-zero after reset; plain RAM macros would not allow this.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q      <= state_d;
      idx_q        <= idx_d;
      sweep_done_q <= sweep_done_d;
      wr_drop_q    <= wr_drop_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_reg_file_gen.sv
// Directed self-checking bench for reg_file_gen: three instances cover
// bypass on/off (shared stimulus) and a 16-bit, 16-entry zero-R0 variant.
module tb_reg_file_gen;

  logic clk = 1'b0;
  logic rst_n;

  // Shared stimulus for instances A (BYPASS=1) and B (BYPASS=0).
  logic [2:0]  read_addr1, read_addr2, write_addr;
  logic [31:0] alu, id;
  logic        sel, we, clr;
  logic [1:0]  mode;
  logic [31:0] a_value1, a_value2, b_value1, b_value2;
  logic        a_busy, a_done, a_drop, b_busy, b_done, b_drop;

  // Stimulus for instance C (DATA_W=16, ADDR_W=4, ZERO_R0=1).
  logic [3:0]  c_ra1, c_ra2, c_wa;
  logic [15:0] c_alu, c_id;
  logic        c_sel, c_we, c_clr;
  logic [1:0]  c_mode;
  logic [15:0] c_value1, c_value2;
  logic        c_busy, c_done, c_drop;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  reg_file_gen #(.DATA_W(32), .ADDR_W(3), .BYPASS(1), .ZERO_R0(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .value1(a_value1), .value2(a_value2),
    .write_addr(write_addr), .write_value_alu(alu), .write_value_id(id),
    .write_data_sel(sel), .write_enable(we), .write_mode(mode),
    .clr_all(clr), .busy(a_busy), .sweep_done(a_done), .wr_drop(a_drop)
  );

  reg_file_gen #(.DATA_W(32), .ADDR_W(3), .BYPASS(0), .ZERO_R0(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .value1(b_value1), .value2(b_value2),
    .write_addr(write_addr), .write_value_alu(alu), .write_value_id(id),
    .write_data_sel(sel), .write_enable(we), .write_mode(mode),
    .clr_all(clr), .busy(b_busy), .sweep_done(b_done), .wr_drop(b_drop)
  );

  reg_file_gen #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_R0(1)) dut_c (
    .clk(clk), .rst_n(rst_n),
    .read_addr1(c_ra1), .read_addr2(c_ra2),
    .value1(c_value1), .value2(c_value2),
    .write_addr(c_wa), .write_value_alu(c_alu), .write_value_id(c_id),
    .write_data_sel(c_sel), .write_enable(c_we), .write_mode(c_mode),
    .clr_all(c_clr), .busy(c_busy), .sweep_done(c_done), .wr_drop(c_drop)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write on the shared A/B port.
  task automatic wr(input logic [2:0] a, input logic [31:0] v, input logic [1:0] m,
                    input logic s);
    write_addr = a;
    if (s) id = v; else alu = v;
    sel  = s;
    mode = m;
    we   = 1'b1;
    tick();
    we   = 1'b0;
    mode = 2'b00;
  endtask

  // One-cycle write on the instance C port.
  task automatic cwr(input logic [3:0] a, input logic [15:0] v, input logic [1:0] m);
    c_wa   = a;
    c_id   = v;
    c_sel  = 1'b1;
    c_mode = m;
    c_we   = 1'b1;
    tick();
    c_we   = 1'b0;
    c_mode = 2'b00;
  endtask

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    read_addr1 = '0; read_addr2 = '0; write_addr = '0;
    alu = '0; id = '0; sel = 1'b0; we = 1'b0; clr = 1'b0; mode = 2'b00;
    c_ra1 = '0; c_ra2 = '0; c_wa = '0; c_alu = '0; c_id = '0;
    c_sel = 1'b0; c_we = 1'b0; c_clr = 1'b0; c_mode = 2'b00;

    // Reset state, including a would-be bypass that must stay hidden.
    #12;
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_drop", a_drop, 0);
    we = 1'b1; sel = 1'b1; id = 32'hFFFF; write_addr = 3'd0;
    #1;
    check("rst_value1", a_value1, 0);
    we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // MOV / MOVT sequence on R0.
    wr(3'd0, 32'h0000FFFF, 2'b00, 1'b1);
    wr(3'd0, 32'h0000EEEE, 2'b10, 1'b1);
    read_addr1 = 3'd0;
    #1;
    check("movt_a", a_value1, 32'hEEEEFFFF);
    check("movt_b", b_value1, 32'hEEEEFFFF);
    wr(3'd0, 32'h00001234, 2'b01, 1'b1);
    #1;
    check("movl_a", a_value1, 32'hEEEE1234);
    check("movl_b", b_value1, 32'hEEEE1234);

    // Bypass: full write of 9 over 5, then a high-half bypassed write.
    wr(3'd1, 32'd5, 2'b00, 1'b0);
    read_addr1 = 3'd1; write_addr = 3'd1; alu = 32'd9; sel = 1'b0; mode = 2'b00; we = 1'b1;
    #1;
    check("byp_pre_a", a_value1, 32'd9);
    check("byp_pre_b", b_value1, 32'd5);
    tick();
    we = 1'b0;
    #1;
    check("byp_post_a", a_value1, 32'd9);
    check("byp_post_b", b_value1, 32'd9);
    read_addr2 = 3'd1; alu = 32'h00000003; mode = 2'b10; we = 1'b1;
    #1;
    check("byp_half_a", a_value2, 32'h00030009);
    check("byp_half_b", b_value2, 32'd9);
    tick();
    we = 1'b0; mode = 2'b00;

    // Sweep with a dropped write to R2 in sweep cycle 2.
    for (int i = 0; i < 8; i++) wr(3'(i), 32'h11 * (i + 1), 2'b00, 1'b0);
    read_addr1 = 3'd2; read_addr2 = 3'd3;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 8; k++) begin
      write_addr = 3'd2; alu = 32'hABCD; sel = 1'b0; we = (k == 2);
      #1;
      check($sformatf("sw_busy_%0d", k), a_busy, 1);
      check($sformatf("sw_done_%0d", k), a_done, 0);
      check($sformatf("sw_drop_%0d", k), a_drop, (k == 3));
      check($sformatf("sw_r3_%0d", k), a_value2, (k < 4) ? 32'h44 : 32'h0);
      if (k == 2) check("sw_no_bypass", a_value1, 32'h33);
      tick();
    end
    we = 1'b0;
    #1;
    check("sw_end_busy", a_busy, 0);
    check("sw_end_done", a_done, 1);
    check("sw_end_drop", a_drop, 0);
    tick();
    check("sw_done_pulse", a_done, 0);
    for (int i = 0; i < 8; i++) begin
      read_addr1 = 3'(i);
      #1;
      check($sformatf("sw_zero_a%0d", i), a_value1, 0);
      check($sformatf("sw_zero_b%0d", i), b_value1, 0);
    end
    wr(3'd2, 32'hABCD, 2'b00, 1'b0);
    read_addr1 = 3'd2;
    #1;
    check("idle_write", a_value1, 32'hABCD);
    check("idle_nodrop", a_drop, 0);

    // Reset in the middle of a sweep, then a fresh full sweep.
    wr(3'd5, 32'h55, 2'b00, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    read_addr1 = 3'd5;
    #1;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_r5", a_value1, 0);
    #2;
    rst_n = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    cnt = 0;
    while (a_busy && cnt < 40) begin
      cnt++;
      tick();
    end
    check("fresh_sweep_len", cnt, 8);
    check("fresh_sweep_done", a_done, 1);

    // clr_all held high restarts right after sweep_done.
    tick();
    clr = 1'b1;
    tick();
    cnt = 0;
    while (!a_done && cnt < 40) begin
      cnt++;
      tick();
    end
    check("b2b_len", cnt, 8);
    check("b2b_idle", a_busy, 0);
    tick();
    check("b2b_restart", a_busy, 1);
    clr = 1'b0;
    cnt = 0;
    while (a_busy && cnt < 40) begin
      cnt++;
      tick();
    end
    check("b2b_second_len", cnt, 8);

    // Instance C: zero R0, 16-bit half modes, 16-cycle sweep.
    c_ra1 = 4'd0; c_wa = 4'd0; c_id = 16'hFFFF; c_sel = 1'b1; c_we = 1'b1;
    #1;
    check("z_r0_bypass", c_value1, 0);
    tick();
    c_we = 1'b0;
    #1;
    check("z_r0_read", c_value1, 0);
    check("z_r0_nodrop", c_drop, 0);
    cwr(4'd1, 16'h1234, 2'b00);
    cwr(4'd1, 16'h00AB, 2'b10);
    c_ra2 = 4'd1;
    #1;
    check("c_movt", c_value2, 16'hAB34);
    cwr(4'd1, 16'hFFCD, 2'b01);
    #1;
    check("c_movl", c_value2, 16'hABCD);
    c_clr = 1'b1;
    tick();
    c_clr = 1'b0;
    cnt = 0;
    while (c_busy && cnt < 60) begin
      cnt++;
      tick();
    end
    check("c_sweep_len", cnt, 16);
    check("c_sweep_done", c_done, 1);
    #1;
    check("c_r1_cleared", c_value2, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
